// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one rd/wr memory port between a fetch and a data requester.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              f_valid_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic [DATA_W-1:0] f_rdata_o,
    output logic              f_ack_o,
    output logic              f_err_o,
    input  logic              d_valid_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              d_err_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    output logic              mem_rd_addr_valid_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    input  logic              mem_rd_ack_i,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic              mem_wr_data_valid_o,
    input  logic              mem_wr_ack_i,
    output logic              busy_o,
    output logic              owner_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CW-1:0]     cnt_q;
    logic              we_q, owner_q, rd_valid_q, wr_valid_q;
    logic              f_ack_q, d_ack_q, f_err_q, d_err_q;
    logic              gnt, hit, tmo;
`ifdef ARB_ROUND_ROBIN_EN
    // owner_q holds the last grant, so it serves as rr_last
    assign gnt = (f_valid_i && d_valid_i) ? !owner_q : d_valid_i;
`else
    assign gnt = d_valid_i;
`endif
    // only the ack of the channel actually in use completes the transaction
    assign hit = we_q ? mem_wr_ack_i : mem_rd_ack_i;
    assign tmo = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            owner_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            f_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            f_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (f_valid_i || d_valid_i) begin
                    owner_q    <= gnt;
                    we_q       <= gnt && d_we_i;
                    addr_q     <= gnt ? d_addr_i : f_addr_i;
                    wdata_q    <= d_wdata_i;
                    rd_valid_q <= !(gnt && d_we_i);
                    wr_valid_q <= gnt && d_we_i;
                    state_q    <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (hit || tmo) begin
                    rd_valid_q <= 1'b0;
                    wr_valid_q <= 1'b0;
                    rdata_q    <= (hit && !we_q) ? mem_rd_data_i : '0;
                    f_ack_q    <= !owner_q;
                    d_ack_q    <= owner_q;
                    f_err_q    <= !hit && !owner_q;
                    d_err_q    <= !hit && owner_q;
                    state_q    <= RESP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                RESP: begin
                    rdata_q <= '0;
                    f_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    f_err_q <= 1'b0;
                    d_err_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign f_rdata_o           = rdata_q;
    assign d_rdata_o           = rdata_q;
    assign f_ack_o             = f_ack_q;
    assign d_ack_o             = d_ack_q;
    assign f_err_o             = f_err_q;
    assign d_err_o             = d_err_q;
    assign mem_rd_addr_o       = addr_q;
    assign mem_rd_addr_valid_o = rd_valid_q;
    assign mem_wr_addr_o       = addr_q;
    assign mem_wr_data_o       = wdata_q;
    assign mem_wr_data_valid_o = wr_valid_q;
    assign busy_o              = state_q != IDLE;
    assign owner_o             = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions against a cycle-level reference of the arbiter.
module tb_mem_port_arbiter;
    localparam int TO = 16;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        f_valid_i, d_valid_i, d_we_i;
    logic [31:0] f_addr_i, d_addr_i, d_wdata_i, mem_rd_data_i;
    logic        mem_rd_ack_i, mem_wr_ack_i;
    logic [31:0] f_rdata_o, d_rdata_o, mem_rd_addr_o, mem_wr_addr_o, mem_wr_data_o;
    logic        f_ack_o, f_err_o, d_ack_o, d_err_o;
    logic        mem_rd_addr_valid_o, mem_wr_data_valid_o, busy_o, owner_o;
    int          total = 0;
    int          bad = 0;
    bit          last;
    bit          w;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .f_valid_i(f_valid_i), .f_addr_i(f_addr_i), .f_rdata_o(f_rdata_o),
        .f_ack_o(f_ack_o), .f_err_o(f_err_o),
        .d_valid_i(d_valid_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
        .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_addr_valid_o(mem_rd_addr_valid_o),
        .mem_rd_data_i(mem_rd_data_i), .mem_rd_ack_i(mem_rd_ack_i),
        .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_wr_data_valid_o(mem_wr_data_valid_o), .mem_wr_ack_i(mem_wr_ack_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outputs"}, 64'(|{f_rdata_o, f_ack_o, f_err_o, d_rdata_o, d_ack_o, d_err_o,
                                      mem_rd_addr_o, mem_rd_addr_valid_o, mem_wr_addr_o,
                                      mem_wr_data_o, mem_wr_data_valid_o, owner_o}), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    // Memory answers k cycles after its valid first appears; with noise it also pulses the unused channel's ack.
    task automatic serve(input int k, input bit noise, input logic [31:0] rd, output bit win);
        logic [31:0] ea, ewd;
        bit          ewe, terr;
        int          ec, c, vcnt, ocnt;
        win  = (f_valid_i && d_valid_i) ? (RR ? !last : 1'b1) : d_valid_i;
        last = win;
        ewe  = win && d_we_i;
        ea   = win ? d_addr_i : f_addr_i;
        ewd  = d_wdata_i;
        terr = (TO > 0) && (k > TO);
        ec   = terr ? 2 + TO : 2 + k;
        tick();
        c = 1;
        vcnt = 0;
        ocnt = 0;
        chk("grant_owner", 64'(owner_o), 64'(win));
        chk("issue_busy", 64'(busy_o), 64'd1);
        chk("issue_addr", 64'(ewe ? mem_wr_addr_o : mem_rd_addr_o), 64'(ea));
        if (ewe) chk("issue_wdata", 64'(mem_wr_data_o), 64'(ewd));
        f_addr_i  = $urandom;
        d_addr_i  = $urandom;
        d_wdata_i = $urandom;
        while (!(f_ack_o || d_ack_o) && c < 60) begin
            if (ewe ? mem_wr_data_valid_o : mem_rd_addr_valid_o) vcnt++;
            if (ewe ? mem_rd_addr_valid_o : mem_wr_data_valid_o) ocnt++;
            mem_rd_data_i = (c == 1 + k) ? rd : $urandom;
            mem_rd_ack_i  = ewe ? (noise && c == 2) : (c == 1 + k);
            mem_wr_ack_i  = ewe ? (c == 1 + k) : (noise && c == 2);
            tick();
            c++;
        end
        mem_rd_ack_i = 1'b0;
        mem_wr_ack_i = 1'b0;
        chk("ack_cycle", 64'(c), 64'(ec));
        chk("f_ack", 64'(f_ack_o), 64'(!win));
        chk("d_ack", 64'(d_ack_o), 64'(win));
        chk("f_err", 64'(f_err_o), 64'(!win && terr));
        chk("d_err", 64'(d_err_o), 64'(win && terr));
        if (!ewe) chk("rdata", 64'(win ? d_rdata_o : f_rdata_o), 64'(terr ? 32'd0 : rd));
        chk("valid_cycles", 64'(vcnt), 64'(ec - 1));
        chk("other_channel", 64'(ocnt), 64'd0);
        chk("valid_dropped", 64'(mem_rd_addr_valid_o | mem_wr_data_valid_o), 64'd0);
        chk("addr_held", 64'(ewe ? mem_wr_addr_o : mem_rd_addr_o), 64'(ea));
        if (ewe) chk("wdata_held", 64'(mem_wr_data_o), 64'(ewd));
        if (terr) begin
            mem_rd_ack_i  = !ewe;
            mem_wr_ack_i  = ewe;
            mem_rd_data_i = $urandom;
        end
        tick();
        mem_rd_ack_i = 1'b0;
        mem_wr_ack_i = 1'b0;
        if (win) d_valid_i = 1'b0;
        else f_valid_i = 1'b0;
        chk("ack_one_cycle", 64'(f_ack_o | d_ack_o | f_err_o | d_err_o), 64'd0);
        chk("idle_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        f_valid_i = 1'b0; f_addr_i = '0;
        d_valid_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        mem_rd_data_i = '0; mem_rd_ack_i = 1'b0; mem_wr_ack_i = 1'b0;
        last = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst_i = 1'b0;
        tick();
        chk_zero("idle_after_reset");
        f_valid_i = 1'b1; f_addr_i = 32'h100;
        serve(1, 1'b0, 32'hDEADBEEF, w);
        chk("fetch_owner", 64'(w), 64'd0);
        f_valid_i = 1'b1; f_addr_i = $urandom;
        d_valid_i = 1'b1; d_we_i = 1'($urandom); d_addr_i = $urandom; d_wdata_i = $urandom;
        for (int i = 0; i < 4; i++) begin
            serve(1 + i, 1'b0, $urandom, w);
            chk("both_grant", 64'(w), 64'((i % 2 == 0) || !RR));
            if (i < 3 && w) begin
                d_valid_i = 1'b1; d_we_i = 1'($urandom); d_addr_i = $urandom; d_wdata_i = $urandom;
            end else if (i < 3) begin
                f_valid_i = 1'b1; f_addr_i = $urandom;
            end
        end
        serve(2, 1'b0, $urandom, w);
        chk("pending_grant", 64'(w), 64'(RR));
        d_valid_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'h12345678;
        serve(2, 1'b0, 32'h0, w);
        chk("write_owner", 64'(w), 64'd1);
        f_valid_i = 1'b1; f_addr_i = 32'h400;
        serve(4, 1'b1, $urandom, w);
        d_valid_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h440;
        serve(3, 1'b1, $urandom, w);
        f_valid_i = 1'b1; f_addr_i = 32'h480;
        serve(TO, 1'b0, $urandom, w);
        f_valid_i = 1'b1; f_addr_i = 32'h300;
        serve(1000, 1'b0, $urandom, w);
        mem_rd_ack_i = 1'b1;
        mem_rd_data_i = $urandom;
        tick();
        mem_rd_ack_i = 1'b0;
        chk("late_ack_idle_busy", 64'(busy_o), 64'd0);
        chk("late_ack_no_resp", 64'(f_ack_o | d_ack_o), 64'd0);
        tick();
        chk("late_ack_still_idle", 64'(busy_o | f_ack_o | d_ack_o), 64'd0);
        f_valid_i = 1'b1; f_addr_i = 32'h500;
        tick();
        tick();
        tick();
        chk("pre_reset_busy", 64'(busy_o), 64'd1);
        chk("pre_reset_valid", 64'(mem_rd_addr_valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        f_valid_i = 1'b0;
        #1;
        chk_zero("async_reset");
        tick();
        chk_zero("reset_held");
        rst_i = 1'b0;
        last = 1'b0;
        tick();
        chk_zero("reset_released");
        f_valid_i = 1'b1; f_addr_i = 32'h600;
        serve(1, 1'b0, $urandom, w);
        chk("after_reset_owner", 64'(w), 64'd0);
        for (int i = 0; i < 24; i++) begin
            if (!f_valid_i && 1'($urandom)) begin
                f_valid_i = 1'b1; f_addr_i = $urandom;
            end
            if (!d_valid_i && (1'($urandom) || !f_valid_i)) begin
                d_valid_i = 1'b1; d_we_i = 1'($urandom); d_addr_i = $urandom; d_wdata_i = $urandom;
            end
            serve(($urandom_range(0, 7) == 0) ? TO + 1 + int'($urandom_range(0, 3)) : int'($urandom_range(1, 5)),
                  1'($urandom), $urandom, w);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
